// File: rtl/rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_reg
// Purpose  : N-channel registered multiplexer with valid/ready handshakes on
//            every input and on the output. One requesting channel is chosen
//            per cycle, using round-robin or fixed-priority arbitration. The
//            winner's word is captured into a single output register.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            mode       - 0 = round-robin, 1 = fixed priority (lowest wins)
//            in_data    - N_CH packed words, channel i at [i*WIDTH +: WIDTH]
//            in_valid   - per-channel word present
//            in_ready   - per-channel word accepted this cycle
//            out_data   - registered selected word
//            out_sel    - index of the channel that produced out_data
//            out_valid  - out_data/out_sel hold a word
//            out_ready  - consumer takes out_data this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_reg #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W:0]   c_n_ch_ext = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] c_last_ch  = SEL_W'(N_CH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_found;
    logic [SEL_W-1:0] w_win;
    logic [SEL_W:0]   w_idx;
    logic [N_CH-1:0]  w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_win_data;
    logic [SEL_W-1:0] w_ptr_nxt;

    // Register is empty, or its current word leaves this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Arbitration. Both scans run from the far end toward the preferred
    // start so that the last hit written is the highest-priority one.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        if (mode) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    w_found = 1'b1;
                    w_win   = SEL_W'(i);
                end
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                // ptr + k folded back into 0..N_CH-1; one subtraction is
                // enough because ptr and k are both below N_CH.
                w_idx = {1'b0, r_ptr} + (SEL_W+1)'(k);
                if (w_idx >= c_n_ch_ext) begin
                    w_idx = w_idx - c_n_ch_ext;
                end
                if (in_valid[w_idx[SEL_W-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_idx[SEL_W-1:0];
                end
            end
        end
    end

    assign w_grant  = w_found ? (N_CH'(1) << w_win) : '0;
    assign w_accept = w_load_en && w_found;

    // Gating with rst_n keeps every in_ready low while reset is held, even
    // though the cleared register would otherwise report itself free.
    assign in_ready = w_grant & {N_CH{w_load_en && rst_n}};

    // Winner data select by index compare; only the registered path sees it.
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_win == SEL_W'(i)) begin
                w_win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Explicit wrap so a non-power-of-2 N_CH never yields ptr >= N_CH.
    assign w_ptr_nxt = (w_win == c_last_ch) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_win_data;
            r_out_sel   <= w_win;
            r_out_valid <= 1'b1;
            if (!mode) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            // Drained with nothing to replace it; data/sel keep last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_reg
// Purpose  : Self-checking bench for rr_mux_reg (N_CH=4, WIDTH=8). Accepted
//            words are queued when driven and compared when they reach the
//            output register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_reg;

    localparam logic [31:0] RR_DATA = 32'h1312_1110;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        mode      = 1'b0;
    logic [31:0] in_data   = '0;
    logic [3:0]  in_valid  = '0;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    rr_mux_reg #(.N_CH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int         errors = 0;
    int         checks = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_w;
    int         m_ptr = 0;
    bit         m_ov  = 1'b0;
    logic [7:0] m_od  = '0;
    logic [1:0] m_os  = '0;
    bit         acc;

    function automatic int exp_win(input logic md, input logic [3:0] v, input int p);
        if (md) begin
            for (int i = 0; i < 4; i++) if (v[i]) return i;
        end else begin
            for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w;
        w = exp_win(mode, in_valid, m_ptr);
        if (!rst_n) return 4'b0000;
        if ((!m_ov || out_ready) && w >= 0) return 4'(1 << w);
        return 4'b0000;
    endfunction

    task automatic drive(input logic md, input logic [3:0] v, input logic [31:0] d, input logic r);
        mode = md; in_valid = v; in_data = d; out_ready = r;
        #1;
    endtask

    // Advance the reference model by one edge, queue any accepted word,
    // then move the DUT through the same edge.
    task automatic tick();
        int w;
        w   = exp_win(mode, in_valid, m_ptr);
        acc = 1'b0;
        if ((!m_ov || out_ready) && w >= 0) begin
            acc  = 1'b1;
            m_os = w[1:0];
            m_od = in_data[w*8 +: 8];
            m_ov = 1'b1;
            sb.push_back({m_os, m_od});
            if (!mode) m_ptr = (w + 1) % 4;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'hF, RR_DATA, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        drive(1'b0, 4'b0100, 32'h00A5_0000, 1'b1);
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
            errors++; $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=a5 s=2", out_valid, out_data, out_sel);
        end
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL single_sb: got %h want %h", {out_sel, out_data}, exp_w); end
        // ptr must now be 3: with every channel requesting, channel 3 wins.
        drive(1'b0, 4'hF, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL single_ptr: got %b want 1000", in_ready); end
        tick();
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL single_sb2: got %h want %h", {out_sel, out_data}, exp_w); end
    endtask

    task automatic test_round_robin();
        int cnt[4];
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 4'hF, RR_DATA, 1'b1);
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, in_ready, exp_ready()); end
            if (c < 4) for (int i = 0; i < 4; i++) cnt[i] += int'(in_ready[i]);
            tick();
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'(c % 4)) begin
                errors++; $display("FAIL rr_sel[%0d]: got v=%b s=%0d want v=1 s=%0d", c, out_valid, out_sel, c % 4);
            end
            if (acc) begin
                exp_w = sb.pop_front();
                checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL rr_sb[%0d]: got %h want %h", c, {out_sel, out_data}, exp_w); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cnt[i] != 1) begin errors++; $display("FAIL rr_fair[%0d]: got %0d grants want 1", i, cnt[i]); end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'hF, RR_DATA, 1'b0);
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== m_od || out_sel !== m_os) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want v=1 d=%h s=%0d", c, out_valid, out_data, out_sel, m_od, m_os);
            end
        end
        drive(1'b0, 4'hF, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release: got %b want 0100", in_ready); end
        tick();
        exp_w = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL bp_sb: got %h want %h", {out_sel, out_data}, exp_w); end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] want;
        // Channel 3 alone moves ptr back to 0 before the priority run.
        drive(1'b0, 4'b1000, RR_DATA, 1'b1);
        tick();
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL fp_pre: got %h want %h", {out_sel, out_data}, exp_w); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'b1010, RR_DATA, 1'b1);
            checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fp_ready[%0d]: got %b want 0010", c, in_ready); end
            tick();
            exp_w = sb.pop_front();
            checks++; if (out_sel !== 2'd1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL fp_out[%0d]: got %h want %h", c, {out_sel, out_data}, exp_w); end
        end
        for (int j = 0; j < 2; j++) begin
            want = (j == 0) ? 2'd1 : 2'd3;
            drive(1'b0, 4'b1010, RR_DATA, 1'b1);
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL fp_rr_ready[%0d]: got %b want %b", j, in_ready, exp_ready()); end
            tick();
            exp_w = sb.pop_front();
            checks++; if (out_sel !== want || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL fp_resume[%0d]: got %h want %h", j, {out_sel, out_data}, exp_w); end
        end
    endtask

    task automatic test_wrap_drain();
        drive(1'b0, 4'b0100, RR_DATA, 1'b1);
        tick();
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL wrap_pre: got %h want %h", {out_sel, out_data}, exp_w); end
        drive(1'b0, 4'b1001, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_g3: got %b want 1000", in_ready); end
        tick();
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL wrap_sb3: got %h want %h", {out_sel, out_data}, exp_w); end
        drive(1'b0, 4'b1001, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_g0: got %b want 0001", in_ready); end
        tick();
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL wrap_sb0: got %h want %h", {out_sel, out_data}, exp_w); end
        drive(1'b0, 4'b0000, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL drain_ready: got %b want 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h10 || out_sel !== 2'd0) begin
            errors++; $display("FAIL drain_out: got v=%b d=%h s=%0d want v=0 d=10 s=0", out_valid, out_data, out_sel);
        end
        // ptr should be 1 after the channel-0 grant.
        drive(1'b0, 4'hF, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL drain_ptr: got %b want 0010", in_ready); end
        tick();
        exp_w = sb.pop_front();
        checks++; if ({out_sel, out_data} !== exp_w) begin errors++; $display("FAIL drain_sb: got %h want %h", {out_sel, out_data}, exp_w); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 4'hF, RR_DATA, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got v=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            errors++; $display("FAIL mid_clear: got v=%b d=%h s=%0d want v=0 d=00 s=0", out_valid, out_data, out_sel);
        end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b want 0000", in_ready); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 4'hF, RR_DATA, 1'b1);
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_first: got %b want 0001", in_ready); end
        tick();
        exp_w = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL mid_sb: got %h want %h", {out_sel, out_data}, exp_w); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_wrap_drain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
